turn_controller: RTL and testbench

//  Sequences a two-player Morse round on one shared key/next/done button set.

---
 rtl/turn_controller.sv | 135 +++++++++++++
 tb/tb_turn_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// turn_controller: sequences a two-player Morse round on shared buttons,
// with per-turn timeout, code compare and a saturating score over MAX_ROUNDS.
module turn_controller #(
  parameter int TURN_CYCLES   = 50_000_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_ROUNDS    = 3,
  parameter int SCORE_W       = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               key_in,
  input  logic               next_in,
  input  logic               done_in,
  input  logic [9:0]         p1_code,
  input  logic [9:0]         p2_code,
  output logic               p1_key,
  output logic               p2_key,
  output logic               p1_next,
  output logic               p2_next,
  output logic               p1_clr_n,
  output logic               p2_clr_n,
  output logic               p1_active,
  output logic               p2_active,
  output logic               timed_out,
  output logic               match,
  output logic               result_valid,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);
  localparam int TW = $clog2(TURN_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [3:0] {
    IDLE, P1_CLR, P1_TURN, P2_CLR, P2_TURN, SETTLE, COMPARE, RESULT, GAME_OVER
  } state_t;
  state_t             state_q;
  logic [TW-1:0]      timer_q;
  logic [SW-1:0]      settle_q;
  logic [3:0]         round_q;
  logic               p1_clr_n_q, p2_clr_n_q, p1_active_q, p2_active_q;
  logic               timed_out_q, match_q, result_valid_q, game_over_q;
  logic [SCORE_W-1:0] score_q;
  logic               match_d;
  logic [SCORE_W-1:0] score_d;
  logic               turn_end;
  // An all-zero code means nothing was entered, so it never counts as a match.
  assign match_d  = (p1_code == p2_code) && (p1_code != '0);
  assign score_d  = (match_d && score_q != '1) ? score_q + SCORE_W'(1) : score_q;
  assign turn_end = done_in || (timer_q == '0);
  assign p1_key       = key_in & p1_active_q;
  assign p2_key       = key_in & p2_active_q;
  assign p1_next      = next_in & p1_active_q;
  assign p2_next      = next_in & p2_active_q;
  assign p1_clr_n     = p1_clr_n_q;
  assign p2_clr_n     = p2_clr_n_q;
  assign p1_active    = p1_active_q;
  assign p2_active    = p2_active_q;
  assign timed_out    = timed_out_q;
  assign match        = match_q;
  assign result_valid = result_valid_q;
  assign score        = score_q;
  assign game_over    = game_over_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      settle_q       <= '0;
      round_q        <= '0;
      p1_clr_n_q     <= 1'b1;
      p2_clr_n_q     <= 1'b1;
      p1_active_q    <= 1'b0;
      p2_active_q    <= 1'b0;
      timed_out_q    <= 1'b0;
      match_q        <= 1'b0;
      result_valid_q <= 1'b0;
      score_q        <= '0;
      game_over_q    <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q    <= P1_CLR;
          p1_clr_n_q <= 1'b0;
          score_q    <= '0;
          round_q    <= '0;
          match_q    <= 1'b0;
        end
        P1_CLR: begin
          state_q     <= P1_TURN;
          p1_clr_n_q  <= 1'b1;
          p1_active_q <= 1'b1;
          timed_out_q <= 1'b0;
          timer_q     <= TW'(TURN_CYCLES - 1);
        end
        P1_TURN: if (turn_end) begin
          state_q     <= P2_CLR;
          p1_active_q <= 1'b0;
          p2_clr_n_q  <= 1'b0;
          timed_out_q <= !done_in;
        end else timer_q <= timer_q - TW'(1);
        P2_CLR: begin
          state_q     <= P2_TURN;
          p2_clr_n_q  <= 1'b1;
          p2_active_q <= 1'b1;
          timed_out_q <= 1'b0;
          timer_q     <= TW'(TURN_CYCLES - 1);
        end
        P2_TURN: if (turn_end) begin
          state_q     <= SETTLE;
          p2_active_q <= 1'b0;
          timed_out_q <= !done_in;
          settle_q    <= SW'(SETTLE_CYCLES - 1);
        end else timer_q <= timer_q - TW'(1);
        SETTLE: if (settle_q == '0) state_q <= COMPARE;
                else settle_q <= settle_q - SW'(1);
        COMPARE: begin
          state_q        <= RESULT;
          match_q        <= match_d;
          score_q        <= score_d;
          round_q        <= round_q + 4'(1);
          result_valid_q <= 1'b1;
        end
        RESULT: if (round_q == 4'(MAX_ROUNDS)) begin
          state_q     <= GAME_OVER;
          game_over_q <= 1'b1;
        end else begin
          state_q    <= P1_CLR;
          p1_clr_n_q <= 1'b0;
        end
        GAME_OVER: state_q <= GAME_OVER;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: randomized turn timing and codes checked against a
// round-level model of the game rules.
module tb_turn_controller;
  localparam int TURN = 16;
  localparam int SETL = 2;
  localparam int MAXR = 2;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0;
  logic key_in = 1'b0, next_in = 1'b0, done_in = 1'b0;
  logic [9:0] p1_code = '0, p2_code = '0;
  logic p1_key, p2_key, p1_next, p2_next, p1_clr_n, p2_clr_n;
  logic p1_active, p2_active, timed_out, match, result_valid, game_over;
  logic [3:0] score;
  logic b_p1_key, b_p2_key, b_p1_next, b_p2_next, b_p1_clr_n, b_p2_clr_n;
  logic b_p1_active, b_p2_active, b_timed_out, b_match, b_result_valid, b_game_over;
  logic [0:0] b_score;
  int n_checks = 0, n_fail = 0;
  int score_m, round_m;
  always #5 clock = ~clock;
  turn_controller #(.TURN_CYCLES(TURN), .SETTLE_CYCLES(SETL), .MAX_ROUNDS(MAXR), .SCORE_W(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .key_in(key_in), .next_in(next_in),
    .done_in(done_in), .p1_code(p1_code), .p2_code(p2_code), .p1_key(p1_key), .p2_key(p2_key),
    .p1_next(p1_next), .p2_next(p2_next), .p1_clr_n(p1_clr_n), .p2_clr_n(p2_clr_n),
    .p1_active(p1_active), .p2_active(p2_active), .timed_out(timed_out), .match(match),
    .result_valid(result_valid), .score(score), .game_over(game_over));
  // Narrow-score variant running three rounds alongside the main instance.
  turn_controller #(.TURN_CYCLES(TURN), .SETTLE_CYCLES(SETL), .MAX_ROUNDS(3), .SCORE_W(1)) dut_b (
    .clock(clock), .resetn(resetn), .start(start), .key_in(key_in), .next_in(next_in),
    .done_in(done_in), .p1_code(p1_code), .p2_code(p2_code), .p1_key(b_p1_key), .p2_key(b_p2_key),
    .p1_next(b_p1_next), .p2_next(b_p2_next), .p1_clr_n(b_p1_clr_n), .p2_clr_n(b_p2_clr_n),
    .p1_active(b_p1_active), .p2_active(b_p2_active), .timed_out(b_timed_out), .match(b_match),
    .result_valid(b_result_valid), .score(b_score), .game_over(b_game_over));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic chk_reset;
    chk("rst_clr_n", {p1_clr_n, p2_clr_n}, 2'b11);
    chk("rst_active", {p1_active, p2_active}, 2'b00);
    chk("rst_flags", {timed_out, match, result_valid, game_over}, 4'b0000);
    chk("rst_score", score, 0);
  endtask
  task automatic start_game;
    resetn = 1'b0; start = 1'b0; done_in = 1'b0;
    tick; tick;
    resetn = 1'b1;
    chk_reset;
    score_m = 0; round_m = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  // Entered at the clear cycle of player pl; returns at the cycle after the turn.
  task automatic do_turn(input int pl, input int w);
    bit press;
    int n, cnt;
    press = (w <= TURN);
    n = press ? w : TURN;
    cnt = 0;
    chk($sformatf("p%0d_clr_pulse", pl), pl == 1 ? p1_clr_n : p2_clr_n, 0);
    tick;
    for (int i = 1; i <= 40; i++) begin
      if ((pl == 1 ? p1_active : p2_active) == 1'b0) break;
      if (i == 1) chk("timed_out_at_turn_start", timed_out, 0);
      cnt++;
      key_in = 1'($urandom);
      next_in = 1'($urandom);
      done_in = press && (i == w);
      #1;
      chk($sformatf("p%0d_gating", pl),
          pl == 1 ? {p1_key, p2_key, p1_next, p2_next} : {p2_key, p1_key, p2_next, p1_next},
          {key_in, 1'b0, next_in, 1'b0});
      tick;
    end
    done_in = 1'b0; key_in = 1'b0; next_in = 1'b0;
    chk($sformatf("p%0d_turn_len", pl), cnt, n);
    chk($sformatf("p%0d_timed_out", pl), timed_out, !press);
    chk($sformatf("p%0d_inactive", pl), pl == 1 ? p1_active : p2_active, 0);
  endtask
  task automatic run_round(input logic [9:0] c1, input logic [9:0] c2, input int w1, input int w2);
    int k;
    bit m;
    p1_code = c1; p2_code = c2;
    do_turn(1, w1);
    do_turn(2, w2);
    key_in = 1'b1; next_in = 1'b1;
    #1 chk("settle_gating", {p1_key, p2_key, p1_next, p2_next}, 0);
    key_in = 1'b0; next_in = 1'b0;
    k = 0;
    while (!result_valid && k < 12) begin
      tick;
      k++;
    end
    chk("result_latency", k, SETL + 1);
    m = (c1 == c2) && (c1 != 0);
    if (m && score_m < 15) score_m++;
    round_m++;
    chk("match", match, m);
    chk("score", score, score_m);
    tick;
    chk("result_pulse", result_valid, 0);
    if (round_m == MAXR) chk("game_over", game_over, 1);
    else begin
      chk("next_round_clr", p1_clr_n, 0);
      chk("not_over", game_over, 0);
    end
  endtask
  initial begin
    int sel;
    logic [9:0] c1, c2;
    tick;
    // Game 1: two matches, P2 done coincides with timer expiry, P1 timeout.
    start_game;
    chk("p2_clr_idle", p2_clr_n, 1);
    run_round(10'h1D7, 10'h1D7, 3, TURN);
    run_round(10'h1D7, 10'h1D7, TURN + 4, $urandom_range(1, TURN));
    chk("b_score_saturated", b_score, 1);
    chk("b_clr_third_round", b_p1_clr_n, 0);
    tick;
    done_in = 1'b1; tick; done_in = 1'b0;
    chk("b_p2_clr", b_p2_clr_n, 0);
    tick;
    done_in = 1'b1; tick; done_in = 1'b0;
    tick; tick; tick;
    chk("b_result", {b_result_valid, b_match}, 2'b11);
    chk("b_score_holds", b_score, 1);
    tick;
    chk("b_game_over", b_game_over, 1);
    start = 1'b1; done_in = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    start = 1'b0; done_in = 1'b0;
    chk("over_held", {game_over, match, p1_clr_n, p1_active, result_valid}, 5'b11100);
    chk("over_score", score, 2);
    // Game 2: all-zero codes and differing codes never match.
    start_game;
    run_round(10'h000, 10'h000, $urandom_range(1, 20), $urandom_range(1, 20));
    run_round(10'h007, 10'h00D, $urandom_range(1, 20), $urandom_range(1, 20));
    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      start_game;
      for (int r = 0; r < MAXR; r++) begin
        sel = $urandom_range(0, 3);
        c1 = 10'($urandom_range(1, 1023));
        c2 = sel == 0 ? c1 : sel == 1 ? c1 ^ (10'd1 << $urandom_range(0, 9)) : 10'($urandom_range(1, 1023));
        if (sel == 3) c1 = '0;
        run_round(c1, c2, $urandom_range(1, 20), $urandom_range(1, 20));
      end
    end
    // Abort during P2 turn.
    start_game;
    p1_code = 10'h1D7; p2_code = 10'h1D7;
    do_turn(1, 5);
    tick;
    chk("p2_active_before_abort", p2_active, 1);
    resetn = 1'b0;
    tick;
    chk_reset;
    resetn = 1'b1;
    tick;
    chk("idle_after_abort", {p1_clr_n, p1_active, p2_active}, 3'b100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
